fpcvt_serial_loader: RTL

Upstream input stage for the FPCVT floating-point converter. Receives the 12-bit two's-complement sample D as a strobed serial bit stream, MSB first. It assembles the word in a shift register and presents it on a registered parallel output with a valid/ready handshake. The converter's D input is driven from `d`; `d` only changes at frame completion, so the converter always sees a stable, complete word.

---
 rtl/fpcvt_serial_loader_if.sv | 30 +++
 rtl/fpcvt_serial_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fpcvt_serial_loader_if.sv
// rtl/fpcvt_serial_loader_if.sv - serial-in / parallel-out handshake bundle for fpcvt_serial_loader
interface fpcvt_serial_loader_if;
    logic        sin;
    logic        bit_stb;
    logic        d_ready;
    logic [11:0] d;
    logic        d_valid;
    logic        busy;
    logic        err;

    modport master (
        output sin,
        output bit_stb,
        output d_ready,
        input  d,
        input  d_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  sin,
        input  bit_stb,
        input  d_ready,
        output d,
        output d_valid,
        output busy,
        output err
    );
endinterface

// File: rtl/fpcvt_serial_loader.sv
// rtl/fpcvt_serial_loader.sv - strobed MSB-first serial loader for the FPCVT D word (optional FPCVT_PARITY_EN)
module fpcvt_serial_loader #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    fpcvt_serial_loader_if.slave  bus
);

`ifdef FPCVT_PARITY_EN
    localparam int N = 13;
`else
    localparam int N = 12;
`endif

    localparam logic [3:0]  LAST_BIT  = 4'(N - 1);
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [N-2:0]  shift_q;
    logic [3:0]    bit_cnt;
    logic [15:0]   idle_cnt;
    logic [11:0]   d_q;
    logic          d_valid_q;
    logic          busy_q;
    logic          err_q;
    logic [N-1:0]  frame_next;
    logic          frame_ok;

    // The frame as it would look after shifting in the current bit.
    always_comb begin
        frame_next = {shift_q, bus.sin};
`ifdef FPCVT_PARITY_EN
        frame_ok   = ~(^frame_next);
`else
        frame_ok   = 1'b1;
`endif
    end

    // Frame state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.bit_stb) begin
                        shift_q  <= {{(N-2){1'b0}}, bus.sin};
                        bit_cnt  <= 4'd1;
                        idle_cnt <= '0;
                        state    <= SHIFT;
                        busy_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.bit_stb) begin
                        idle_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            // Final bit: leave SHIFT either way, publish only a good frame.
                            shift_q <= '0;
                            bit_cnt <= '0;
                            busy_q  <= 1'b0;
                            if (frame_ok) begin
`ifdef FPCVT_PARITY_EN
                                d_q   <= frame_next[N-1:1];
`else
                                d_q   <= frame_next;
`endif
                                d_valid_q <= 1'b1;
                                state     <= HOLD;
                            end else begin
                                err_q <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            shift_q <= frame_next[N-2:0];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        // Stalled too long: drop the partial frame, keep d.
                        err_q    <= 1'b1;
                        shift_q  <= '0;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    // A strobe here is an overrun; the bit is thrown away.
                    if (bus.bit_stb) begin
                        err_q <= 1'b1;
                    end
                    if (d_valid_q && bus.d_ready) begin
                        d_valid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d       = d_q;
    assign bus.d_valid = d_valid_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;

endmodule
